// File: rtl/uart_cmd_parser.sv
// ASCII set-time / set-date frame parser ("Thhmmss\r" / "Dddmmyy\r") sitting behind a UART receiver.
// Range-checks the fields and issues one-cycle load strobes, or cmd_err for bad, out-of-range or stalled frames.
module uart_cmd_parser #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       busy,
  output logic       set_time,
  output logic       set_date,
  output logic       cmd_err,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year
);

  localparam logic [31:0] TIMEOUT_CYCLES = 32'(CLOCK_FREQ / 1000 * TIMEOUT_MS);
  localparam logic [31:0] TIMEOUT_LAST   = TIMEOUT_CYCLES - 32'd1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DIGITS  = 3'd1;
  localparam logic [2:0] S_WAIT_CR = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_ISSUE   = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        is_date_q, is_date_d;
  logic [3:0]  dig_q [6];
  logic [3:0]  dig_d [6];
  logic [31:0] cnt_q, cnt_d;
  logic        rx_ready_q;
  logic        set_time_q, set_time_d;
  logic        set_date_q, set_date_d;
  logic        cmd_err_q, cmd_err_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  minute_q, minute_d;
  logic [5:0]  second_q, second_d;
  logic [4:0]  day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [6:0]  year_q, year_d;

  logic        stb;
  logic        is_cmd, is_date_byte, is_digit, is_cr;
  logic [6:0]  fld [3];
  logic [4:0]  maxday;
  logic        time_ok, date_ok;

  assign stb          = rx_ready & ~rx_ready_q;
  assign is_date_byte = (rx_data == 8'h44) || (rx_data == 8'h64);
  assign is_cmd       = is_date_byte || (rx_data == 8'h54) || (rx_data == 8'h74);
  assign is_digit     = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_cr        = (rx_data == 8'h0D);

  // Field gi is the binary value of BCD digit pair (2*gi, 2*gi+1), tens first.
  for (genvar gi = 0; gi < 3; gi++) begin : g_fld
    assign fld[gi] = {3'b000, dig_q[2*gi]} * 7'd10 + {3'b000, dig_q[2*gi+1]};
  end

  // Binary year: yy%4 == 0 is just the two low bits being zero.
  always_comb begin
    maxday = 5'd31;
    case (fld[1])
      7'd4, 7'd6, 7'd9, 7'd11: maxday = 5'd30;
      7'd2:                    maxday = (fld[2][1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 maxday = 5'd31;
    endcase
  end

  assign time_ok = (fld[0] <= 7'd23) && (fld[1] <= 7'd59) && (fld[2] <= 7'd59);
  assign date_ok = (fld[1] >= 7'd1) && (fld[1] <= 7'd12) &&
                   (fld[0] >= 7'd1) && (fld[0] <= {2'b00, maxday});

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    is_date_d  = is_date_q;
    dig_d      = dig_q;
    set_time_d = 1'b0;
    set_date_d = 1'b0;
    cmd_err_d  = 1'b0;
    hour_d     = hour_q;
    minute_d   = minute_q;
    second_d   = second_q;
    day_d      = day_q;
    month_d    = month_q;
    year_d     = year_q;

    case (state_q)
      S_IDLE: begin
        if (stb && is_cmd) begin
          is_date_d = is_date_byte;
          idx_d     = 3'd0;
          state_d   = S_DIGITS;
        end
      end
      S_DIGITS: begin
        if (stb) begin
          if (is_digit) begin
            dig_d[idx_q] = rx_data[3:0];
            idx_d        = idx_q + 3'd1;
            if (idx_q == 3'd5) state_d = S_WAIT_CR;
          end else begin
            state_d = S_ERR;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_WAIT_CR: begin
        if (stb) begin
          state_d = is_cr ? S_CHECK : S_ERR;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_CHECK: begin
        state_d = (is_date_q ? date_ok : time_ok) ? S_ISSUE : S_ERR;
      end
      S_ISSUE: begin
        if (is_date_q) begin
          day_d      = fld[0][4:0];
          month_d    = fld[1][3:0];
          year_d     = fld[2];
          set_date_d = 1'b1;
        end else begin
          hour_d     = fld[0][4:0];
          minute_d   = fld[1][5:0];
          second_d   = fld[2][5:0];
          set_time_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_ERR: begin
        cmd_err_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte gap counter only runs while a frame is waiting on the receiver.
    if (!stb && ((state_q == S_DIGITS) || (state_q == S_WAIT_CR))) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      is_date_q  <= 1'b0;
      cnt_q      <= 32'd0;
      rx_ready_q <= 1'b0;
      set_time_q <= 1'b0;
      set_date_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      hour_q     <= 5'd0;
      minute_q   <= 6'd0;
      second_q   <= 6'd0;
      day_q      <= 5'd1;
      month_q    <= 4'd1;
      year_q     <= 7'd0;
      for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      is_date_q  <= is_date_d;
      cnt_q      <= cnt_d;
      rx_ready_q <= rx_ready;
      set_time_q <= set_time_d;
      set_date_q <= set_date_d;
      cmd_err_q  <= cmd_err_d;
      hour_q     <= hour_d;
      minute_q   <= minute_d;
      second_q   <= second_d;
      day_q      <= day_d;
      month_q    <= month_d;
      year_q     <= year_d;
      for (int i = 0; i < 6; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign set_time = set_time_q;
  assign set_date = set_date_q;
  assign cmd_err  = cmd_err_q;
  assign hour     = hour_q;
  assign minute   = minute_q;
  assign second   = second_q;
  assign day      = day_q;
  assign month    = month_q;
  assign year     = year_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a byte-level frame model predicts each strobe,
// a negedge monitor pops and compares whenever set_time/set_date/cmd_err is seen.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int CF  = 100000;
  localparam int TMS = 1;
  localparam int TC  = CF / 1000 * TMS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       busy, set_time, set_date, cmd_err;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;

  uart_cmd_parser #(.CLOCK_FREQ(CF), .TIMEOUT_MS(TMS)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .busy(busy), .set_time(set_time), .set_date(set_date), .cmd_err(cmd_err),
    .hour(hour), .minute(minute), .second(second),
    .day(day), .month(month), .year(year)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // kind: {set_time, set_date, cmd_err}; cyc < 0 means arrival time not checked
  typedef struct {
    logic [2:0] kind;
    int hh, mi, ss, dd, mo, yy;
    int cyc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] fbuf[$];
  int m_hh = 0, m_mi = 0, m_ss = 0, m_dd = 1, m_mo = 1, m_yy = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push_exp(input logic [2:0] k, input int c);
    exp_t e;
    e.kind = k;
    e.hh = m_hh; e.mi = m_mi; e.ss = m_ss;
    e.dd = m_dd; e.mo = m_mo; e.yy = m_yy;
    e.cyc = c;
    sb.push_back(e);
  endfunction

  function automatic bit is_cmd(input logic [7:0] b);
    return (b == 8'h54) || (b == 8'h74) || (b == 8'h44) || (b == 8'h64);
  endfunction

  function automatic int dval(input logic [7:0] b);
    return int'(b) - 48;
  endfunction

  // Complete frame in fbuf (cmd + 6 digits) followed by CR: decide the outcome.
  function automatic void eval_frame(input int c);
    int mdays[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int a, b, d, lim;
    bit is_t, ok;
    a = dval(fbuf[1]) * 10 + dval(fbuf[2]);
    b = dval(fbuf[3]) * 10 + dval(fbuf[4]);
    d = dval(fbuf[5]) * 10 + dval(fbuf[6]);
    is_t = (fbuf[0] == 8'h54) || (fbuf[0] == 8'h74);
    if (is_t) begin
      ok = (a <= 23) && (b <= 59) && (d <= 59);
    end else begin
      ok = (b >= 1) && (b <= 12);
      if (ok) begin
        lim = mdays[b - 1];
        if (b == 2 && d % 4 == 0) lim = 29;
        ok = (a >= 1) && (a <= lim);
      end
    end
    if (!ok) push_exp(3'b001, c);
    else if (is_t) begin
      m_hh = a; m_mi = b; m_ss = d;
      push_exp(3'b100, c);
    end else begin
      m_dd = a; m_mo = b; m_yy = d;
      push_exp(3'b010, c);
    end
  endfunction

  // c = cycle count at the negedge where rx_ready rises; strobe edge is c+1.
  function automatic void model_byte(input logic [7:0] b, input int c);
    if (fbuf.size() == 0) begin
      if (is_cmd(b)) fbuf.push_back(b);
    end else if (fbuf.size() < 7) begin
      if (b >= 8'h30 && b <= 8'h39) fbuf.push_back(b);
      else begin
        fbuf.delete();
        push_exp(3'b001, c + 2);
      end
    end else begin
      if (b == 8'h0D) eval_frame(c + 3);
      else push_exp(3'b001, c + 2);
      fbuf.delete();
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    model_byte(b, cyc);
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_msg(input string s, input bit cr, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hold, 2);
    if (cr) send_byte(8'h0D, hold, 2);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_strobes"}, int'({set_time, set_date, cmd_err}), 0);
    check({tag, "_hour"}, int'(hour), 0);
    check({tag, "_minute"}, int'(minute), 0);
    check({tag, "_second"}, int'(second), 0);
    check({tag, "_day"}, int'(day), 1);
    check({tag, "_month"}, int'(month), 1);
    check({tag, "_year"}, int'(year), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (set_time || set_date || cmd_err)) begin
      $display("txn cyc=%0d st=%b sd=%b err=%b hms=%0d:%0d:%0d dmy=%0d/%0d/%0d",
               cyc, set_time, set_date, cmd_err, hour, minute, second, day, month, year);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got %b expected no strobe", {set_time, set_date, cmd_err});
      end else begin
        e = sb.pop_front();
        check("strobe_kind", int'({set_time, set_date, cmd_err}), int'(e.kind));
        check("hour", int'(hour), e.hh);
        check("minute", int'(minute), e.mi);
        check("second", int'(second), e.ss);
        check("day", int'(day), e.dd);
        check("month", int'(month), e.mo);
        check("year", int'(year), e.yy);
        check("busy_at_strobe", int'(busy), 0);
        if (e.cyc >= 0) check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[8];
    int v0, v1, v2, hold, gap;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_held");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst_rel");

    send_msg("T235959", 1'b1, 1); drain("drain_t235959");
    send_msg("d290224", 1'b1, 1); drain("drain_leap");
    send_msg("D290223", 1'b1, 1); drain("drain_nonleap");
    send_msg("T240000", 1'b1, 1);
    send_msg("D310412", 1'b1, 1);
    send_msg("D001299", 1'b1, 1); drain("drain_ranges");
    send_msg("T12a", 1'b0, 1);
    send_msg("T010203", 1'b1, 1); drain("drain_badchar");
    send_msg("T123456X", 1'b0, 1);
    send_msg("T010203", 1'b1, 1); drain("drain_nocr");
    send_byte(8'h0D, 1, 2);
    send_byte(8'h0A, 1, 2);
    send_msg("T101112", 1'b1, 1); drain("drain_crlf");

    send_msg("T12", 1'b0, 1);
    check("busy_partial", int'(busy), 1);
    push_exp(3'b001, -1);
    fbuf.delete();
    repeat (TC + 20) @(negedge clk);
    check("busy_after_timeout", int'(busy), 0);
    check("timeout_seen", sb.size(), 0);
    send_msg("T121314", 1'b1, 1); drain("drain_after_timeout");

    send_msg("T050607", 1'b1, 5); drain("drain_held_ready");

    send_msg("D1503", 1'b0, 1);
    check("busy_mid_date", int'(busy), 1);
    reset = 1'b1;
    fbuf.delete();
    m_hh = 0; m_mi = 0; m_ss = 0; m_dd = 1; m_mo = 1; m_yy = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst_mid");
    reset = 1'b0;
    @(negedge clk);
    send_msg("D150325", 1'b1, 1); drain("drain_after_reset");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        fr[0] = ($urandom_range(0, 1) == 0) ? 8'h54 : 8'h74;
        v0 = $urandom_range(0, 25); v1 = $urandom_range(0, 61); v2 = $urandom_range(0, 61);
      end else begin
        fr[0] = ($urandom_range(0, 1) == 0) ? 8'h44 : 8'h64;
        v0 = $urandom_range(0, 32); v1 = $urandom_range(0, 13); v2 = $urandom_range(0, 99);
      end
      fr[1] = 8'(48 + v0 / 10); fr[2] = 8'(48 + v0 % 10);
      fr[3] = 8'(48 + v1 / 10); fr[4] = 8'(48 + v1 % 10);
      fr[5] = 8'(48 + v2 / 10); fr[6] = 8'(48 + v2 % 10);
      fr[7] = 8'h0D;
      if ($urandom_range(0, 7) == 0) fr[$urandom_range(1, 7)] = 8'(8'h41 + $urandom_range(0, 25));
      if ($urandom_range(0, 5) == 0) begin
        send_byte(8'h0D, 1, 2);
        send_byte(8'h0A, 1, 2);
      end
      for (int i = 0; i < 8; i++) begin
        hold = $urandom_range(1, 3);
        gap  = $urandom_range(2, 5);
        send_byte(fr[i], hold, gap);
      end
      drain("drain_random");
    end

    repeat (10) @(negedge clk);
    check("final_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Byte-level command sequencer behind the UART receiver. It consumes received bytes and parses ASCII set-time / set-date frames. After range-checking the fields, it issues single-cycle load strobes with binary field values to the calendar/clock registers. Malformed, out-of-range or stalled frames are rejected with an error pulse.

Parameters:
CLOCK_FREQ, 100000000, system clock frequency in Hz
TIMEOUT_MS, 100, maximum gap between bytes of one frame, in ms; TIMEOUT_CYCLES = CLOCK_FREQ/1000*TIMEOUT_MS

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_data  input  8  byte from the UART receiver, valid while rx_ready is high
rx_ready  input  1  receiver byte-valid flag; only its rising edge counts
busy  output  1  high while a frame is in progress (any state other than IDLE)
set_time  output  1  one-cycle strobe; hour/minute/second are valid and new
set_date  output  1  one-cycle strobe; day/month/year are valid and new
cmd_err  output  1  one-cycle strobe; frame rejected
hour  output  5  0..23
minute  output  6  0..59
second  output  6  0..59
day  output  5  1..31
month  output  4  1..12
year  output  7  0..99, meaning 2000..2099

Behaviour:
- Reset: asynchronous, active-high. All state returns to IDLE and all counters clear.
  - busy, set_time, set_date and cmd_err = 0.
  - hour, minute and second = 0; day = 1; month = 1; year = 0.
  - A reset mid-frame discards the partial frame and emits no strobe.
- Byte strobe: stb = rx_ready & ~rx_ready_q, where rx_ready_q is registered. Exactly one byte is taken per rising edge of rx_ready. A level held high counts once.
- Frame format: cmd, d0..d5, CR.
  - cmd is 'T'/'t' (0x54/0x74) for time or 'D'/'d' (0x44/0x64) for date.
  - d0..d5 are ASCII '0'..'9' (0x30..0x39) and form three 2-digit decimal fields, tens digit first: T = hh mm ss, D = dd mm yy.
  - CR = 0x0D.
- States:
  - IDLE: on stb with a cmd byte, latch the type, clear the digit index, go to DIGITS. Any other byte is ignored silently, with no error, so stray CR/LF is tolerated.
  - DIGITS: on stb with a digit, store it as 4-bit BCD at the current index and increment the index. After the 6th digit, go to WAIT_CR. On a non-digit, go to ERR.
  - WAIT_CR: on stb with CR, go to CHECK. Any other byte goes to ERR.
  - CHECK (1 cycle, no stb needed): field = tens*10 + ones, computed in binary. Valid ranges:
    - time: hh ≤ 23, mm ≤ 59, ss ≤ 59.
    - date: 1 ≤ mm ≤ 12 and 1 ≤ dd ≤ maxday, with year = yy.
    - maxday = 30 for months 4, 6, 9 and 11; 29 for month 2 when yy%4 == 0; 28 for month 2 otherwise; 31 for all other months.
    - Valid goes to ISSUE; invalid goes to ERR.
  - ISSUE (1 cycle): load the three output fields of the frame type and assert set_time or set_date for this one cycle, then go to IDLE. The other frame type's fields are unchanged.
  - ERR (1 cycle): assert cmd_err, then go to IDLE. No field output changes.
- Latency: if the CR strobe is sampled at edge N, the set_*/cmd_err strobe is high during the cycle following edge N+2. Field outputs change on the same edge that raises the strobe.
- Field outputs hold their values until the next valid frame of the same type.
- Timeout: an inter-byte counter, at least 32 bits wide.
  - It clears on every stb and whenever the state is IDLE.
  - It increments in DIGITS and WAIT_CR.
  - When it reaches TIMEOUT_CYCLES-1 with no stb, the block goes to ERR: cmd_err pulse, then IDLE.
  - If stb arrives on the same cycle as the terminal count, stb wins.
- Bytes arriving during CHECK, ISSUE or ERR: the 2-cycle window is far shorter than one UART byte time. Any stb in it is still dropped, with no error.
- A cmd byte received mid-frame is a non-digit: ERR, and no restart.
- At most one of set_time, set_date and cmd_err is high in any cycle.

Test Plan:
- "T235959\r" → set_time pulse 2 cycles after the CR strobe; hour = 23, minute = 59, second = 59; date fields unchanged; busy drops with the pulse.
- "d290224\r" then "D290223\r" → first: set_date, day = 29, month = 2, year = 24; second: cmd_err, fields remain 29/2/24.
- "T240000\r", "D310412\r", "D001299\r" → three cmd_err pulses, no set_* pulse.
- "T12a", and separately "T123456X" → cmd_err on the bad byte plus 1 cycle; the following "T010203\r" gives hour = 1, minute = 2, second = 3. Leading "\r\n" before a frame → no error.
- With CLOCK_FREQ reduced for simulation: send "T12", then idle TIMEOUT_CYCLES → exactly one cmd_err and busy = 0. Resend the full frame → success. Hold rx_ready high for 5 cycles → exactly one byte consumed.
- Assert reset after "D1503" → all outputs at reset values. The next "D150325\r" → day = 15, month = 3, year = 25.
